// File: rtl/cplq_pkg.sv
// Shared definitions for the NVMe completion-queue poll sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cplq_pkg;

  localparam int CQ_ENTRY_BYTES = 16;
  localparam int PHASE_BIT      = 112;
  localparam int STATUS_MSB     = 127;
  localparam int STATUS_LSB     = 113;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    CHECK,
    GAP,
    RING,
    DONE
  } cplq_state_e;

  // Completion entry as seen on the read data path. The phase tag sits at
  // bit 112 and the status field fills bits 127:113.
  typedef struct packed {
    logic [STATUS_MSB-STATUS_LSB:0] status;
    logic                           phase;
    logic [PHASE_BIT-1:0]           body;
  } cq_entry_t;

endpackage

// File: rtl/cplq_head_tracker.sv
// Owns the CQ head index and the expected phase tag; wraps and flips phase together.
// Latency: head/phase update on the clock edge after advance is asserted.
// Backpressure: none; advance is taken every cycle it is high.
module cplq_head_tracker #(
  parameter int AW = 6
) (
  input  logic          aclk,
  input  logic          reset,
  input  logic          advance,
  output logic [AW-1:0] cq_head,
  output logic          exp_phase,
  output logic          wrap
);

  logic [AW-1:0] head_q, head_d;
  logic          phase_q, phase_d;

  // Next head and phase: a wrap from the last slot back to 0 flips the phase.
  always_comb begin
    head_d  = head_q;
    phase_d = phase_q;
    wrap    = advance && (head_q == {AW{1'b1}});
    if (advance) begin
      head_d = head_q + AW'(1);
      if (wrap) begin
        phase_d = ~phase_q;
      end
    end
  end

  // Head/phase registers; a fresh queue expects phase 1 at slot 0.
  always_ff @(posedge aclk) begin
    if (reset) begin
      head_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      phase_q <= phase_d;
    end
  end

  assign cq_head   = head_q;
  assign exp_phase = phase_q;

endmodule

// File: rtl/cplq_poll_sequencer.sv
// Polls one NVMe completion queue until a target count of new entries arrives, ringing the head doorbell in batches.
// Latency: one read round trip plus one CHECK cycle per entry; a stale entry is re-polled after POLL_GAP idle cycles.
// Backpressure: read request and doorbell hold valid/address/data stable until ready; read responses are never stalled.
// Optional: define CPLQ_STATUS_CHECK_EN to count new completions with non-zero status in err_count.
module cplq_poll_sequencer #(
  parameter int          CPL_ENTRY_ADDR_WIDTH = 6,
  parameter logic [31:0] CQ_BASE              = 32'h7600_0000,
  parameter logic [31:0] DB_ADDR              = 32'h7000_1004,
  parameter int          DB_BATCH             = 4,
  parameter int          POLL_GAP             = 8
) (
  input  logic                            aclk,
  input  logic                            reset,
  input  logic                            go,
  input  logic [31:0]                     num_cmds_to_wait,
  output logic                            done,
  output logic                            rd_req_valid,
  input  logic                            rd_req_ready,
  output logic [31:0]                     rd_req_addr,
  input  logic                            rd_rsp_valid,
  input  logic [127:0]                    rd_rsp_data,
  output logic                            db_valid,
  input  logic                            db_ready,
  output logic [31:0]                     db_addr,
  output logic [31:0]                     db_data,
  output logic [CPL_ENTRY_ADDR_WIDTH-1:0] cq_head,
  output logic                            exp_phase,
  output logic [15:0]                     err_count
);

  import cplq_pkg::*;

  cplq_state_e state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [31:0] got_q, got_d;
  logic [31:0] batch_q, batch_d;
  logic [31:0] gap_q, gap_d;
  cq_entry_t   entry_q, entry_d;
  logic        advance;
  logic        head_wrap;
  logic        gap_last;

  cplq_head_tracker #(
    .AW (CPL_ENTRY_ADDR_WIDTH)
  ) u_head (
    .aclk      (aclk),
    .reset     (reset),
    .advance   (advance),
    .cq_head   (cq_head),
    .exp_phase (exp_phase),
    .wrap      (head_wrap)
  );

  // A POLL_GAP of 0 or 1 degenerates to a single idle cycle.
  assign gap_last = (POLL_GAP <= 1) || (gap_q >= 32'(POLL_GAP - 1));

  // Next-state, counters and handshake outputs.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    got_d        = got_q;
    batch_d      = batch_q;
    gap_d        = gap_q;
    entry_d      = entry_q;
    advance      = 1'b0;
    rd_req_valid = 1'b0;
    db_valid     = 1'b0;

    case (state_q)
      // A new go from DONE restarts exactly as from IDLE.
      IDLE, DONE: begin
        if (go) begin
          target_d = num_cmds_to_wait;
          got_d    = '0;
          batch_d  = '0;
          state_d  = (num_cmds_to_wait == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        rd_req_valid = 1'b1;
        if (rd_req_ready) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rd_rsp_valid) begin
          entry_d = cq_entry_t'(rd_rsp_data);
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (entry_q.phase == exp_phase) begin
          advance = 1'b1;
          got_d   = got_q + 32'd1;
          batch_d = batch_q + 32'd1;
          state_d = ((got_d == target_q) || (batch_d == 32'(DB_BATCH))) ? RING : ISSUE;
        end else begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_last) begin
          state_d = ISSUE;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      RING: begin
        db_valid = 1'b1;
        if (db_ready) begin
          batch_d = '0;
          state_d = (got_q == target_q) ? DONE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state; reset aborts any run, so a late response lands in IDLE and is dropped.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      got_q    <= '0;
      batch_q  <= '0;
      gap_q    <= '0;
      entry_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      got_q    <= got_d;
      batch_q  <= batch_d;
      gap_q    <= gap_d;
      entry_q  <= entry_d;
    end
  end

  assign done        = (state_q == DONE);
  assign rd_req_addr = CQ_BASE + (32'(cq_head) * 32'(CQ_ENTRY_BYTES));
  assign db_addr     = DB_ADDR;
  assign db_data     = 32'(cq_head);

`ifdef CPLQ_STATUS_CHECK_EN
  logic [15:0] err_q, err_d;
  logic        unused_bits;

  // Count new completions that report an error, saturating rather than wrapping.
  always_comb begin
    err_d = err_q;
    if (advance && (entry_q.status != '0) && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  // Error counter survives across runs; only reset clears it.
  always_ff @(posedge aclk) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count   = err_q;
  assign unused_bits = ^{entry_q.body, head_wrap};
`else
  logic unused_bits;

  assign err_count   = '0;
  assign unused_bits = ^{entry_q.body, entry_q.status, head_wrap};
`endif

endmodule
